// File: rtl/spi_flash_reader.sv
// SPI flash read sequencer: issues a READ command with a 24-bit address through
// the SPI TX FIFO, drains the response from the RX FIFO, drops the four header
// bytes, and packs the data bytes little-endian into 32-bit words.
module spi_flash_reader #(
    parameter logic [7:0] CMD_READ = 8'h03
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [23:0] req_addr_i,
    input  logic [7:0]  req_words_i,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    input  logic        rdata_ready_i,
    output logic        done_o,
    output logic        tx_fifo_write_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_fifo_full_i,
    output logic        rx_fifo_read_o,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_fifo_empty_i,
    input  logic        spi_busy_i
);

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned HDR_LEN = 4;
    localparam int unsigned MAX_INFLIGHT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_XFER   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]    tx_cnt;
    logic [CNT_W-1:0]    rx_cnt;
    logic [CNT_W-1:0]    total;
    logic [CNT_W-1:0]    total_req;
    logic [ADDR_W-1:0]   addr;
    logic [23:0]         stage;
    logic [8:0]          words_ext;
    logic                accept;
    logic                push;
    logic                pop;
    logic                out_stall;
    logic                done_set;
    logic [BYTE_W-1:0]   tx_byte;

    // Request length in bytes: header plus four bytes per word, 0 words meaning 256.
    always_comb begin
        words_ext = (req_words_i == 8'd0) ? 9'd256 : {1'b0, req_words_i};
        total_req = CNT_W'(HDR_LEN) + {words_ext, 2'b00};
    end

    // Byte presented to the TX FIFO, selected by how many have been pushed so far.
    always_comb begin
        tx_byte = '0;
        case (tx_cnt)
            CNT_W'(0): tx_byte = CMD_READ;
            CNT_W'(1): tx_byte = addr[23:16];
            CNT_W'(2): tx_byte = addr[15:8];
            CNT_W'(3): tx_byte = addr[7:0];
            default:   tx_byte = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and FIFO handshakes; TX is throttled so no more than four bytes
    // are ever outstanding in the SPI loop, RX stops while a word awaits its consumer.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        done_set  = 1'b0;
        out_stall = rdata_valid_o && !rdata_ready_i;
        case (state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    accept    = 1'b1;
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                push = !tx_fifo_full_i && (tx_cnt < total)
                       && ((tx_cnt - rx_cnt) < CNT_W'(MAX_INFLIGHT));
                pop  = !rx_fifo_empty_i && (rx_cnt < total) && !out_stall;
                if ((rx_cnt == total) && !rdata_valid_o) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                if (!spi_busy_i) begin
                    done_set  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign tx_fifo_write_o = push;
    assign rx_fifo_read_o  = pop;
    assign tx_data_o       = push ? tx_byte : '0;

    // Handshake outputs follow the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_o <= 1'b1;
            done_o      <= 1'b0;
        end else begin
            req_ready_o <= (state_nxt == ST_IDLE);
            done_o      <= done_set;
        end
    end

    // Counters and word assembly; lanes 0..2 collect in a staging register so the
    // word on rdata_o is only replaced when the fourth byte completes a new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt        <= '0;
            rx_cnt        <= '0;
            total         <= '0;
            addr          <= '0;
            stage         <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
        end else begin
            if (accept) begin
                addr   <= req_addr_i;
                total  <= total_req;
                tx_cnt <= '0;
                rx_cnt <= '0;
                stage  <= '0;
            end
            if (push) begin
                tx_cnt <= tx_cnt + CNT_W'(1);
            end
            if (rdata_valid_o && rdata_ready_i) begin
                rdata_valid_o <= 1'b0;
            end
            if (pop) begin
                rx_cnt <= rx_cnt + CNT_W'(1);
                // Header length is a multiple of four, so the lane is rx_cnt[1:0].
                if (rx_cnt >= CNT_W'(HDR_LEN)) begin
                    case (rx_cnt[1:0])
                        2'd0: stage[7:0]   <= rx_data_i;
                        2'd1: stage[15:8]  <= rx_data_i;
                        2'd2: stage[23:16] <= rx_data_i;
                        default: begin
                            rdata_o       <= {rx_data_i, stage};
                            rdata_valid_o <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: loopback SPI FIFO model, random stalls, and a
// reference built from the command/address/data byte layout.
module tb_spi_flash_reader;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [23:0] req_addr_i;
    logic [7:0]  req_words_i;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        rdata_ready_i;
    logic        done_o;
    logic        tx_fifo_write_o;
    logic [7:0]  tx_data_o;
    logic        tx_fifo_full_i;
    logic        rx_fifo_read_o;
    logic [7:0]  rx_data_i;
    logic        rx_fifo_empty_i;
    logic        spi_busy_i;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [7:0] rxq[$];

    spi_flash_reader #(.CMD_READ(8'h03)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_words_i(req_words_i),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i),
        .done_o(done_o),
        .tx_fifo_write_o(tx_fifo_write_o), .tx_data_o(tx_data_o), .tx_fifo_full_i(tx_fifo_full_i),
        .rx_fifo_read_o(rx_fifo_read_o), .rx_data_i(rx_data_i), .rx_fifo_empty_i(rx_fifo_empty_i),
        .spi_busy_i(spi_busy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Flash content seen on the wire after the header; seed 0 gives AA BB CC DD ...
    function automatic logic [7:0] data_byte(input int unsigned seed, input int k);
        if (seed == 0) return 8'(32'hAA + 32'h11 * k);
        return 8'((seed >> (k % 17)) ^ 32'(k * 97) ^ 32'(k >> 3));
    endfunction

    function automatic logic [31:0] exp_word(input int unsigned seed, input int j);
        return {data_byte(seed, 4*j+3), data_byte(seed, 4*j+2),
                data_byte(seed, 4*j+1), data_byte(seed, 4*j)};
    endfunction

    function automatic logic [7:0] exp_tx(input logic [23:0] a, input int idx);
        case (idx)
            0:       return 8'h03;
            1:       return a[23:16];
            2:       return a[15:8];
            3:       return a[7:0];
            default: return 8'h00;
        endcase
    endfunction

    task automatic idle_inputs();
        req_valid_i     = 1'b0;
        tx_fifo_full_i  = 1'b0;
        rx_fifo_empty_i = 1'b1;
        rx_data_i       = 8'h00;
        rdata_ready_i   = 1'b1;
        spi_busy_i      = 1'b0;
    endtask

    // One read transaction against the loopback model. gap_at<0 disables the
    // consumer gap, busy_hold>0 extends spi_busy after the last pop, abort_at>0
    // resets the DUT once that many bytes were pushed.
    task automatic run_txn(input logic [23:0] addr, input logic [7:0] words, input int stall_pct,
                           input int gap_at, input int busy_hold, input int unsigned seed,
                           input int abort_at);
        int total, nwords, pushes, pops, words_got, done_cnt, busy_cnt, fall_c, c;
        bit finished, prev_valid, prev_ready, busy, push, pop;
        logic [31:0] prev_data;
        nwords = (words == 8'd0) ? 256 : int'(words);
        total  = 4 + 4 * nwords;
        pushes = 0; pops = 0; words_got = 0; done_cnt = 0; busy_cnt = 0; fall_c = -1; c = 0;
        finished = 1'b0; prev_valid = 1'b0; prev_ready = 1'b1; prev_data = '0;
        rxq.delete();
        req_addr_i  = addr;
        req_words_i = words;
        while (!finished && c < 20000) begin
            @(negedge clk);
            req_valid_i = (c == 0) || (c < 8 && $urandom_range(1) == 1);
            if (c > 0) req_addr_i = 24'($urandom);
            tx_fifo_full_i  = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
            rx_fifo_empty_i = (rxq.size() == 0) || ((stall_pct > 0) && ($urandom_range(99) < stall_pct));
            rx_data_i = 8'h00;
            if (rxq.size() > 0) rx_data_i = rxq[0];
            rdata_ready_i = !(gap_at >= 0 && c >= gap_at && c < gap_at + 20)
                            && ((stall_pct == 0) || ($urandom_range(99) >= 20));
            busy = (pushes != pops) || (busy_cnt > 0);
            spi_busy_i = busy;
            if (busy_cnt > 0) busy_cnt--;
            if (busy_hold > 0 && pops == total && !busy && fall_c < 0) fall_c = c;
            #3;
            if (c == 0) check("req_ready_idle", 64'(req_ready_o), 64'(1));
            push = tx_fifo_write_o;
            pop  = rx_fifo_read_o;
            check("push_while_full", 64'(push && tx_fifo_full_i), 64'(0));
            check("pop_while_empty", 64'(pop && rx_fifo_empty_i), 64'(0));
            check("pop_while_word_pending", 64'(pop && rdata_valid_o && !rdata_ready_i), 64'(0));
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 64'(rdata_valid_o), 64'(1));
                check("hold_data", 64'(rdata_o), 64'(prev_data));
            end
            prev_valid = rdata_valid_o; prev_ready = rdata_ready_i; prev_data = rdata_o;
            if (rdata_valid_o && rdata_ready_i) begin
                if (words_got < nwords) check("word", 64'(rdata_o), 64'(exp_word(seed, words_got)));
                else check("extra_word", 64'(words_got), 64'(nwords - 1));
                words_got++;
            end
            if (pop) begin
                if (rxq.size() > 0) void'(rxq.pop_front());
                pops++;
                if (pops == total) busy_cnt = busy_hold;
            end
            if (push) begin
                if (pushes < total) check("tx_byte", 64'(tx_data_o), 64'(exp_tx(addr, pushes)));
                else check("tx_overrun", 64'(pushes), 64'(total - 1));
                rxq.push_back(pushes < 4 ? 8'($urandom) : data_byte(seed, pushes - 4));
                pushes++;
            end
            check("in_flight_le4", 64'(pushes - pops <= 4), 64'(1));
            if (done_o) begin
                done_cnt++;
                check("done_words", 64'(words_got), 64'(nwords));
                check("done_pops", 64'(pops), 64'(total));
                if (busy_hold > 0) check("done_after_busy_fall", 64'(c), 64'(fall_c + 1));
                finished = 1'b1;
            end
            if (abort_at > 0 && pushes >= abort_at) begin
                #1 rst_n = 1'b0;
                #1;
                check("rst_req_ready", 64'(req_ready_o), 64'(1));
                check("rst_tx_write", 64'(tx_fifo_write_o), 64'(0));
                check("rst_rx_read", 64'(rx_fifo_read_o), 64'(0));
                check("rst_rdata_valid", 64'(rdata_valid_o), 64'(0));
                check("rst_rdata", 64'(rdata_o), 64'(0));
                check("rst_done", 64'(done_o), 64'(0));
                idle_inputs();
                repeat (3) begin
                    @(negedge clk);
                    #3 check("rst_no_done", 64'(done_o), 64'(0));
                end
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            c++;
        end
        if (!finished) check("txn_timeout", 64'(finished), 64'(1));
        @(negedge clk);
        idle_inputs();
        #3;
        check("done_one_cycle", 64'(done_o), 64'(0));
        check("ready_after_done", 64'(req_ready_o), 64'(1));
        check("total_pushes", 64'(pushes), 64'(total));
        check("total_pops", 64'(pops), 64'(total));
        check("total_words", 64'(words_got), 64'(nwords));
        check("done_count", 64'(done_cnt), 64'(1));
    endtask

    initial begin
        int unsigned s;
        logic [23:0] a;
        rst_n       = 1'b0;
        req_addr_i  = '0;
        req_words_i = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #3;
        check("reset_req_ready", 64'(req_ready_o), 64'(1));
        check("reset_rdata_valid", 64'(rdata_valid_o), 64'(0));
        check("reset_rdata", 64'(rdata_o), 64'(0));
        check("reset_done", 64'(done_o), 64'(0));
        check("reset_tx_write", 64'(tx_fifo_write_o), 64'(0));
        check("reset_rx_read", 64'(rx_fifo_read_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #3 check("ready_after_reset", 64'(req_ready_o), 64'(1));

        // Single word, known data.
        run_txn(24'h123456, 8'd1, 0, -1, 0, 0, 0);
        // 256 words via length 0.
        run_txn(24'($urandom), 8'd0, 0, -1, 0, $urandom | 1, 0);
        // Consumer stalls for 20 cycles mid-stream.
        run_txn(24'($urandom), 8'd8, 0, 15, 0, $urandom | 1, 0);
        // Same content unstalled and with 50% FIFO stalls.
        s = $urandom | 1;
        a = 24'($urandom);
        run_txn(a, 8'd16, 0, -1, 0, s, 0);
        run_txn(a, 8'd16, 50, -1, 0, s, 0);
        // spi_busy held for 10 cycles after the last pop.
        run_txn(24'($urandom), 8'd2, 0, -1, 10, $urandom | 1, 0);
        // Reset after six pushes, then a clean transaction.
        run_txn(24'($urandom), 8'd4, 0, -1, 0, $urandom | 1, 6);
        run_txn(24'($urandom), 8'd3, 30, -1, 0, $urandom | 1, 0);
        // Assorted random transactions.
        for (int i = 0; i < 4; i++) begin
            run_txn(24'($urandom), 8'($urandom_range(20, 1)), 30, -1, 0, $urandom | 1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 SHALL have parameter CMD_READ, default 8'h03, meaning the opcode sent as byte 0 of every transaction.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid_i  input  1  read request valid.
REQ-005 SHALL have port req_ready_o  output  1  request accepted on cycles where valid and ready are both high.
REQ-006 SHALL have port req_addr_i  input  24  flash byte address.
REQ-007 SHALL have port req_words_i  input  8  number of 32-bit words to read; 0 means 256.
REQ-008 SHALL have port rdata_o  output  32  assembled read word.
REQ-009 SHALL have port rdata_valid_o  output  1  rdata_o valid.
REQ-010 SHALL have port rdata_ready_i  input  1  consumer accepts the word.
REQ-011 SHALL have port done_o  output  1  one-cycle transaction-complete pulse.
REQ-012 SHALL have port tx_fifo_write_o  output  1  push tx_data_o into the SPI TX FIFO.
REQ-013 SHALL have port tx_data_o  output  8  byte to transmit.
REQ-014 SHALL have port tx_fifo_full_i  input  1  SPI TX FIFO full.
REQ-015 SHALL have port rx_fifo_read_o  output  1  pop rx_data_i from the SPI RX FIFO.
REQ-016 SHALL have port rx_data_i  input  8  RX FIFO head byte, valid when not empty.
REQ-017 SHALL have port rx_fifo_empty_i  input  1  SPI RX FIFO empty.
REQ-018 SHALL have port spi_busy_i  input  1  SPI controller mid-frame or chip-select active.

Function
REQ-019 SHALL implement the states IDLE, XFER and FINISH.
REQ-020 SHALL drive req_ready_o high only in IDLE; on acceptance SHALL latch the address and TOTAL = 4 + 4*words (11 bits; words 0 -> 256, giving TOTAL 1028), clear tx_cnt and rx_cnt (11 bits each), and enter XFER.
REQ-021 SHALL push bytes in this order: CMD_READ, addr[23:16], addr[15:8], addr[7:0], then 8'h00 for each remaining byte. tx_data_o is selected by tx_cnt.
REQ-022 SHALL assert tx_fifo_write_o in XFER iff !tx_fifo_full_i && tx_cnt < TOTAL && (tx_cnt - rx_cnt) < 4. tx_cnt increments on each push.
REQ-023 SHALL assert rx_fifo_read_o in XFER iff !rx_fifo_empty_i && rx_cnt < TOTAL && !(rdata_valid_o && !rdata_ready_i). rx_cnt increments on each pop.
REQ-024 SHALL discard popped bytes with rx_cnt < 4.
REQ-025 SHALL place popped data bytes little-endian: byte index k = rx_cnt-4 goes to rdata_o[8*(k%4)+7 : 8*(k%4)].
REQ-026 SHALL set rdata_valid_o in the cycle after the pop with k%4 == 3.
REQ-027 SHALL hold rdata_valid_o and keep rdata_o stable until rdata_ready_i is high. A pop and a handshake in the same cycle are legal; the new byte goes into a staging register and does not corrupt the word being output.
REQ-028 SHALL move from XFER to FINISH when rx_cnt reaches TOTAL and no word is pending output.
REQ-029 SHALL, in FINISH, wait for spi_busy_i == 0, then pulse done_o for exactly one cycle and return to IDLE.
REQ-030 SHALL never assert tx_fifo_write_o or rx_fifo_read_o outside XFER, and SHALL ignore req_valid_i outside IDLE.
REQ-031 SHALL tolerate rx_fifo_empty_i and tx_fifo_full_i toggling every cycle without losing or duplicating bytes.

Reset
REQ-032 SHALL, while rst_n is low, asynchronously set the state to IDLE, clear both counters and rdata_o, and hold all outputs low except req_ready_o.
REQ-033 SHALL drive req_ready_o high in the first cycle after rst_n deasserts.
REQ-034 SHALL, on reset mid-transaction, abandon the transaction with no done_o pulse.

Verification
REQ-035 SHALL pass: addr 0x123456, words 1, loopback model -> TX bytes 03 12 34 56 00 00 00 00; RX bytes AA BB CC DD after header -> one word 0xDDCCBBAA, then done_o.
REQ-036 SHALL pass: words 0 -> exactly 1028 pushes, 1028 pops and 256 words, with done_o once.
REQ-037 SHALL pass: rdata_ready_i low for 20 cycles mid-stream -> no pops while a word is pending, tx_cnt - rx_cnt never exceeds 4, and no data lost.
REQ-038 SHALL pass: tx_fifo_full_i and rx_fifo_empty_i randomly asserted 50% of cycles -> byte order and word values identical to the unstalled run.
REQ-039 SHALL pass: spi_busy_i held high for 10 cycles after the last pop -> done_o occurs in the cycle after spi_busy_i falls, and req_ready_o is high in the following cycle.
REQ-040 SHALL pass: rst_n pulsed low after 6 pushes -> outputs cleared immediately, no done_o, and a new request afterwards completes correctly.
